// File: rtl/prefetch_fifo_dwc.sv
// Prefetch (first-word-fall-through) FIFO with a down-sizing width converter.
// Wide words are stored in a circular buffer. The head word is moved into a
// holding register and is read out one RD_DATA_WIDTH slice per rd_en.
//
// state    | meaning
// ---------|----------------------------------------------------------
// ST_EMPTY | holding register has no valid data, rd_vld=0
// ST_FULL  | holding register valid, rd_data = slice sidx, rd_vld=1
module prefetch_fifo_dwc #(
  parameter int RD_DATA_WIDTH = 16,
  parameter int RATIO         = 8,
  parameter int DEPTH_WIDTH   = 9,
  parameter int LSB_FIRST     = 1,
  parameter int AF_THRESH     = 2**DEPTH_WIDTH - 4,
  parameter int AE_THRESH     = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       flush,
  input  logic                                       wr_en,
  input  logic [RD_DATA_WIDTH*RATIO-1:0]             wr_data,
  output logic                                       wr_vld,
  input  logic                                       rd_en,
  output logic                                       rd_vld,
  output logic [RD_DATA_WIDTH-1:0]                   rd_data,
  output logic [DEPTH_WIDTH:0]                       wr_count,
  output logic [DEPTH_WIDTH+$clog2(RATIO):0]         rd_count,
  output logic                                       almost_full,
  output logic                                       almost_empty,
  output logic                                       overflow,
  output logic                                       underflow
);

  localparam int WR_W  = RD_DATA_WIDTH * RATIO;
  localparam int RLOG  = $clog2(RATIO);
  localparam int SW    = (RLOG > 0) ? RLOG : 1;
  localparam int DEPTH = 2**DEPTH_WIDTH;
  localparam int RC_W  = DEPTH_WIDTH + RLOG + 1;

  localparam logic [DEPTH_WIDTH:0] WC_FULL = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_T    = (DEPTH_WIDTH+1)'(AF_THRESH);
  localparam logic [RC_W-1:0]      AE_T    = RC_W'(AE_THRESH);
  localparam logic [SW-1:0]        S_LAST  = SW'(RATIO - 1);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t                  state_q, state_d;
  logic [WR_W-1:0]         mem [DEPTH];
  logic [WR_W-1:0]         hold;
  logic [DEPTH_WIDTH-1:0]  wr_ptr, rd_ptr;
  logic [SW-1:0]           sidx, sidx_d;
  logic [SW-1:0]           slice_idx;
  logic [DEPTH_WIDTH:0]    wr_count_d;
  logic [RC_W-1:0]         rd_count_d;
  logic                    wr_acc, load, has_word, last_sub;

  assign wr_vld       = (wr_count != WC_FULL);
  assign rd_vld       = (state_q == ST_FULL);
  assign has_word     = (wr_count != '0);
  assign last_sub     = (sidx == S_LAST);
  assign wr_acc       = wr_en & wr_vld & ~flush;
  assign almost_full  = (wr_count >= AF_T);
  assign almost_empty = (rd_count <= AE_T);

  // Select the output slice; sub-word order follows LSB_FIRST
  always_comb begin
    slice_idx = (LSB_FIRST != 0) ? sidx : (S_LAST - sidx);
    rd_data   = hold[slice_idx*RD_DATA_WIDTH +: RD_DATA_WIDTH];
  end

  // Output-stage next state: first-word load, sub-word stepping, bubble-free reload
  always_comb begin
    state_d = state_q;
    sidx_d  = sidx;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (has_word) begin
          load    = 1'b1;
          sidx_d  = '0;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (rd_en) begin
          if (!last_sub) begin
            sidx_d = sidx + SW'(1);
          end else if (has_word) begin
            load   = 1'b1;
            sidx_d = '0;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // sidx is left alone on flush so rd_data keeps its last value
    if (flush) begin
      state_d = ST_EMPTY;
      sidx_d  = sidx;
      load    = 1'b0;
    end
  end

  // Next storage occupancy and readable sub-word count
  always_comb begin
    wr_count_d = wr_count;
    case ({wr_acc, load})
      2'b10:   wr_count_d = wr_count + (DEPTH_WIDTH+1)'(1);
      2'b01:   wr_count_d = wr_count - (DEPTH_WIDTH+1)'(1);
      default: wr_count_d = wr_count;
    endcase
    if (flush) wr_count_d = '0;
    rd_count_d = RC_W'(wr_count_d) << RLOG;
    if (state_d == ST_FULL) begin
      rd_count_d = rd_count_d + (RC_W'(RATIO) - RC_W'(sidx_d));
    end
  end

  // Storage array write port (no reset needed, contents gated by counts)
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // State, pointers, counts, holding register and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      sidx      <= '0;
      hold      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      sidx     <= sidx_d;
      wr_count <= wr_count_d;
      rd_count <= rd_count_d;
      if (load) hold <= mem[rd_ptr];
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + DEPTH_WIDTH'(1);
        if (load)   rd_ptr <= rd_ptr + DEPTH_WIDTH'(1);
        if (wr_en && !wr_vld) overflow  <= 1'b1;
        if (rd_en && !rd_vld) underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prefetch_fifo_dwc.sv
// Testbench for prefetch_fifo_dwc: three instances (default LSB-first,
// MSB-first sharing the same stimulus, and a shallow DEPTH_WIDTH=2 copy).
module tb_prefetch_fifo_dwc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic         flush_s = 1'b0, wr_en_s = 1'b0, rd_en_s = 1'b0;

  logic        wr_vld, rd_vld, af, ae, ovf, unf;
  logic [15:0] rd_data;
  logic [9:0]  wr_count;
  logic [12:0] rd_count;

  logic        wr_vld_m, rd_vld_m, af_m, ae_m, ovf_m, unf_m;
  logic [15:0] rd_data_m;
  logic [9:0]  wr_count_m;
  logic [12:0] rd_count_m;

  logic        wr_vld_s, rd_vld_s, af_s, ae_s, ovf_s, unf_s;
  logic [15:0] rd_data_s;
  logic [2:0]  wr_count_s;
  logic [5:0]  rd_count_s;

  int n_cmp = 0, n_err = 0, n_pop = 0;
  logic [15:0] q[$];
  logic [15:0] qm[$];

  always #5 clk = ~clk;

  prefetch_fifo_dwc u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_vld(wr_vld), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .wr_count(wr_count), .rd_count(rd_count), .almost_full(af), .almost_empty(ae),
    .overflow(ovf), .underflow(unf));

  prefetch_fifo_dwc #(.LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_vld(wr_vld_m), .rd_en(rd_en), .rd_vld(rd_vld_m), .rd_data(rd_data_m),
    .wr_count(wr_count_m), .rd_count(rd_count_m), .almost_full(af_m), .almost_empty(ae_m),
    .overflow(ovf_m), .underflow(unf_m));

  prefetch_fifo_dwc #(.DEPTH_WIDTH(2), .AF_THRESH(3)) u_small (
    .clk(clk), .rst_n(rst_n), .flush(flush_s), .wr_en(wr_en_s), .wr_data(wr_data),
    .wr_vld(wr_vld_s), .rd_en(rd_en_s), .rd_vld(rd_vld_s), .rd_data(rd_data_s),
    .wr_count(wr_count_s), .rd_count(rd_count_s), .almost_full(af_s), .almost_empty(ae_s),
    .overflow(ovf_s), .underflow(unf_s));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sub-word k of test word i; word 0 gives 0x0100, 0x0302 ... 0x0F0E
  function automatic logic [15:0] sw_val(input int i, input int k);
    logic [7:0] b;
    b = i[7:0];
    return {8'(2*k+1) ^ b, 8'(2*k) ^ b};
  endfunction

  function automatic logic [127:0] mk_word(input int i);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = sw_val(i, k);
    return w;
  endfunction

  task automatic push_word(input int i);
    for (int k = 0; k < 8; k++) begin
      q.push_back(sw_val(i, k));
      qm.push_back(sw_val(i, 7-k));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop and compare whenever a sub-word is consumed
  always @(negedge clk) begin
    if (rst_n && rd_vld && rd_en) begin
      if (q.size() == 0) check("sb_lsb_unexpected", {48'd0, rd_data}, 64'hFFFF_FFFF);
      else check("sb_lsb", rd_data, q.pop_front());
      n_pop++;
    end
    if (rst_n && rd_vld_m && rd_en) begin
      if (qm.size() == 0) check("sb_msb_unexpected", {48'd0, rd_data_m}, 64'hFFFF_FFFF);
      else check("sb_msb", rd_data_m, qm.pop_front());
    end
  end

  // Write nw words back-to-back from index base while reading continuously
  task automatic stream(input int nw, input int base);
    int wi, target, drops, gaps;
    bit started;
    wi = 0; drops = 0; gaps = 0; started = 0;
    target = n_pop + nw*8;
    for (int i = 0; i < nw; i++) push_word(base + i);
    wr_data = mk_word(base);
    wr_en = 1'b1;
    for (int c = 0; c < nw*8 + 40; c++) begin
      @(negedge clk);
      if (wr_en && !wr_vld) drops++;
      if (rd_en && !rd_vld) gaps++;
      tick();
      if (wr_en) begin
        wi++;
        if (wi < nw) wr_data = mk_word(base + wi);
        else wr_en = 1'b0;
      end
      if (rd_vld) started = 1;
      rd_en = started && (n_pop < target);
      if (started && !rd_en && !wr_en) break;
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    check("stream_pops", n_pop, target);
    check("stream_wr_vld_drops", drops, 0);
    check("stream_gaps", gaps, 0);
    check("stream_overflow", ovf, 0);
    check("stream_underflow", unf, 0);
    check("stream_end_rd_vld", rd_vld, 0);
    check("stream_end_rd_count", rd_count, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc_e[5], rc_e[5], af_e[5], wv_e[5];
    wc_e = '{1, 1, 2, 3, 4};
    rc_e = '{8, 16, 24, 32, 40};
    af_e = '{0, 0, 0, 1, 1};
    wv_e = '{1, 1, 1, 1, 0};

    // Reset values while rst_n is low
    #3;
    check("rst_wr_vld", wr_vld, 1);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_almost_full", af, 0);
    check("rst_almost_empty", ae, 1);
    check("rst_flags", {ovf, unf}, 0);
    check("rst_small_af", af_s, 0);
    #20 rst_n = 1'b1;
    tick();

    // Single word: latency, order in both LSB-first and MSB-first builds
    wr_data = mk_word(0);
    wr_en = 1'b1;
    push_word(0);
    tick();
    wr_en = 1'b0;
    check("t1_rd_vld_edge1", rd_vld, 0);
    check("t1_wr_count_edge1", wr_count, 1);
    check("t1_rd_count_edge1", rd_count, 8);
    check("t1_ae_edge1", ae, 0);
    tick();
    check("t1_rd_vld_edge2", rd_vld, 1);
    check("t1_wr_count_edge2", wr_count, 0);
    check("t1_rd_count_edge2", rd_count, 8);
    check("t1_first_lsb", rd_data, 16'h0100);
    check("t1_first_msb", rd_data_m, 16'h0F0E);
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t1_rd_count_step", rd_count, 7 - k);
    end
    rd_en = 1'b0;
    check("t1_end_rd_vld", rd_vld, 0);
    check("t1_end_almost_empty", ae, 1);
    check("t1_end_msb_rd_vld", rd_vld_m, 0);
    check("t1_sb_drained", q.size() + qm.size(), 0);

    // Streaming: 64 words, 512 sub-words
    tick();
    stream(64, 1);

    // Read while empty
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("uf_flag", unf, 1);
    check("uf_rd_vld", rd_vld, 0);
    check("uf_wr_count", wr_count, 0);
    check("uf_rd_count", rd_count, 0);

    // Flush mid-stream with a write on the same edge
    wr_data = mk_word(10);
    wr_en = 1'b1;
    tick();
    wr_data = mk_word(11);
    tick();
    check("fl_pre_rd_vld", rd_vld, 1);
    check("fl_pre_wr_count", wr_count, 1);
    wr_data = mk_word(12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wr_en = 1'b0;
    check("fl_rd_vld", rd_vld, 0);
    check("fl_wr_count", wr_count, 0);
    check("fl_rd_count", rd_count, 0);
    check("fl_wr_vld", wr_vld, 1);
    check("fl_almost_empty", ae, 1);
    check("fl_flags", {ovf, unf}, 0);
    check("fl_rd_data_held", rd_data, sw_val(10, 0));
    tick();
    tick();
    check("fl_no_store_rd_vld", rd_vld, 0);
    check("fl_no_store_wr_count", wr_count, 0);

    // Fill the shallow instance without reading
    for (int i = 0; i < 5; i++) begin
      wr_data = mk_word(20 + i);
      wr_en_s = 1'b1;
      tick();
      check("fill_wr_count", wr_count_s, wc_e[i]);
      check("fill_rd_count", rd_count_s, rc_e[i]);
      check("fill_almost_full", af_s, af_e[i]);
      check("fill_wr_vld", wr_vld_s, wv_e[i]);
    end
    check("fill_ovf_before", ovf_s, 0);
    wr_data = mk_word(25);
    tick();
    wr_en_s = 1'b0;
    check("fill_ovf_after", ovf_s, 1);
    check("fill_wr_count_hold", wr_count_s, 4);
    check("fill_head", rd_data_s, sw_val(20, 0));
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    check("fill_flush_ovf", ovf_s, 0);
    check("fill_flush_wr_count", wr_count_s, 0);

    // Asynchronous reset in the middle of a read-out
    wr_data = mk_word(5);
    wr_en = 1'b1;
    push_word(5);
    tick();
    wr_en = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    rd_en = 1'b0;
    #1;
    check("arst_rd_vld", rd_vld, 0);
    check("arst_rd_data", rd_data, 0);
    check("arst_rd_count", rd_count, 0);
    check("arst_wr_vld", wr_vld, 1);
    check("arst_almost_empty", ae, 1);
    q.delete();
    qm.delete();
    #12 rst_n = 1'b1;
    tick();
    stream(1, 6);

    check("final_sb_empty", q.size() + qm.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prefetch_fifo_dwc.md
Name: prefetch_fifo_dwc

Overview:
- Single-clock first-word-fall-through (prefetch) FIFO with a parametrised down-sizing data-width converter: wide write words, narrow read sub-words.
- Successor to the fixed 128→16 prefetch read FIFO. Adds a generic width ratio, selectable sub-word order, occupancy counts, almost-full/almost-empty flags, synchronous flush and sticky overflow/underflow error flags.
- Sits between the DDR read-burst engine and pixel-stream consumers (HDMI/LCD timing), all in one clock domain.

Parameters:
- RD_DATA_WIDTH, 16, width of one read sub-word in bits (≥1).
- RATIO, 8, sub-words per write word; must be a power of 2, 1..64. Write width = RD_DATA_WIDTH*RATIO.
- DEPTH_WIDTH, 9, log2 of storage depth in write words; legal 2..12.
- LSB_FIRST, 1, 1: sub-word 0 = wr_data[RD_DATA_WIDTH-1:0]; 0: sub-word 0 = the MS slice.
- AF_THRESH, 2**DEPTH_WIDTH-4, almost_full asserted when wr_count ≥ AF_THRESH.
- AE_THRESH, 4, almost_empty asserted when rd_count ≤ AE_THRESH.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- wr_en  in  1  write strobe.
- wr_data  in  RD_DATA_WIDTH*RATIO  write word.
- wr_vld  out  1  space available (write ready).
- rd_en  in  1  consume the current sub-word.
- rd_vld  out  1  rd_data valid.
- rd_data  out  RD_DATA_WIDTH  current head sub-word (prefetched).
- wr_count  out  DEPTH_WIDTH+1  write words held in storage, excluding the output stage.
- rd_count  out  DEPTH_WIDTH+log2(RATIO)+1  sub-words readable = wr_count*RATIO + sub-words remaining in the output stage.
- almost_full  out  1  wr_count ≥ AF_THRESH.
- almost_empty  out  1  rd_count ≤ AE_THRESH.
- overflow  out  1  sticky: wr_en was seen while wr_vld=0.
- underflow  out  1  sticky: rd_en was seen while rd_vld=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pointers, counts, sub-word index and error flags = 0.
  - wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, almost_empty=1.
- Storage: 2**DEPTH_WIDTH write words with wrap-around pointers, plus one write-word output holding register holding the sub-word index `sidx`.
- Write accept:
  - A write is accepted when wr_en=1 and wr_vld=1. The write pointer advances, wr_count increments.
  - wr_vld = (wr_count != 2**DEPTH_WIDTH). This is combinational from registered state.
- Rejected write: wr_en=1 with wr_vld=0 is dropped. overflow sets and holds until flush or reset.
- Output-stage state machine, two states:
  - EMPTY, entered after reset or flush:
    - If wr_count>0, load the head word into the holding register, sidx=0, go to FULL.
    - rd_vld=0.
  - FULL: rd_vld=1; rd_data = slice sidx of the holding register, ordered per LSB_FIRST.
    - rd_en with sidx<RATIO-1: sidx+1.
    - rd_en with sidx=RATIO-1 and wr_count>0: load the next word and sidx=0 on the same edge. There is no bubble, so sustained rate is one sub-word per clock.
    - rd_en with sidx=RATIO-1 and wr_count=0: go to EMPTY.
- Latency: a write accepted into an empty FIFO at edge N gives rd_vld=1 after edge N+1. The first-word load uses the registered wr_count.
- Simultaneous write and load: wr_count is unchanged (+1 for the write, -1 for the load). Writing when full and reading on the same cycle is still rejected, because wr_vld is based on the registered count.
- Rejected read: rd_en with rd_vld=0 is ignored. underflow sets (sticky).
- RATIO=1: sidx is constant 0, and every rd_en takes the reload path.
- flush:
  - Takes priority over same-cycle wr_en and rd_en.
  - Next cycle returns to the reset state, except rd_data holds its last value.
  - Clears overflow and underflow.
- Counts and flags are registered and valid the cycle after any event. almost_* are derived from the registered counts.
- Reset asserted mid-burst discards all data immediately. No partial sub-word is emitted.

Test Plan:
- Default parameters: write 1 word 0x0F0E_0D0C_0B0A_0908_0706_0504_0302_0100 → rd_vld at the 2nd edge after the write; with rd_en held, rd_data = 0x0100, 0x0302 … 0x0F0E on 8 consecutive cycles; then rd_vld=0, rd_count=0, almost_empty=1.
- Same data with LSB_FIRST=0 → first sub-word 0x0F0E, last 0x0100.
- Streaming: write 64 words back-to-back while rd_en is held high → 512 sub-words with no gaps, in order; wr_vld never drops; overflow=0 and underflow=0.
- Fill: DEPTH_WIDTH=2, no reads: 5 writes accepted (4 in storage + 1 in the output stage) → wr_vld=0, wr_count=4, rd_count=4*8+8=40. A 6th wr_en → dropped, overflow=1. almost_full toggles exactly at AF_THRESH.
- rd_en while empty → underflow=1, no state change. flush asserted mid-stream with wr_en=1 → next cycle rd_vld=0, counts=0, error flags cleared, and the flushed write is not stored.
- Async reset mid-read (rst_n pulsed low between edges) → outputs take their reset values immediately. After release, a new write is read back correctly from sub-word 0.
